// File: rtl/int_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// int_ctrl_pkg
// Shared constants for the memory-mapped interrupt controller and the bridge
// that places it in the address map.
//   INTC_PEND/MASK/MODE/CLAIM : word offsets decoded from Addr[3:2]
//   INTC_BASE_ADDR            : byte base address of the device window
//   SRC_TC0/SRC_TC1/SRC_EXT   : bit positions of the sources on irq_in
// ---------------------------------------------------------------------------
package int_ctrl_pkg;

   localparam logic [1:0] INTC_PEND  = 2'd0;
   localparam logic [1:0] INTC_MASK  = 2'd1;
   localparam logic [1:0] INTC_MODE  = 2'd2;
   localparam logic [1:0] INTC_CLAIM = 2'd3;

   // Third device behind the bridge, directly after the two timer windows.
   localparam logic [31:0] INTC_BASE_ADDR = 32'h0000_7F20;

   localparam int SRC_TC0 = 0;
   localparam int SRC_TC1 = 1;
   localparam int SRC_EXT = 2;

endpackage

// File: rtl/int_src_cell.sv
// ---------------------------------------------------------------------------
// int_src_cell
// One interrupt source: mode bit, previous-sample flop and pending flop.
//   clk, reset : system clock, synchronous active-high reset
//   irq_in     : raw request for this source (synchronous to clk)
//   mode_we    : MODE register written on this edge
//   mode_din   : new mode bit (1 = edge, 0 = level)
//   clr        : W1C or EOI aimed at this source on this edge
//   pend       : pending flag
//   mode       : current mode bit
// ---------------------------------------------------------------------------
module int_src_cell (
   input  logic clk,
   input  logic reset,
   input  logic irq_in,
   input  logic mode_we,
   input  logic mode_din,
   input  logic clr,
   output logic pend,
   output logic mode
);

   logic pend_reg, pend_next;
   logic prev_reg;
   logic mode_reg, mode_next;

   always_comb begin
      pend_next = pend_reg;
      mode_next = mode_we ? mode_din : mode_reg;
      if (mode_we && mode_din && !mode_reg) begin
         // Level to edge: start clean. prev tracks irq_in in every mode, so
         // a line already held high is not seen as a fresh rise next edge.
         pend_next = 1'b0;
      end else if (mode_reg) begin
         // Edge mode: a new rise beats a clear on the same edge.
         pend_next = (irq_in && !prev_reg) || (pend_reg && !clr);
      end else begin
         pend_next = irq_in;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pend_reg <= 1'b0;
         prev_reg <= 1'b0;
         mode_reg <= 1'b0;
      end else begin
         pend_reg <= pend_next;
         prev_reg <= irq_in;
         mode_reg <= mode_next;
      end
   end

   assign pend = pend_reg;
   assign mode = mode_reg;

endmodule

// File: rtl/int_ctrl.sv
// ---------------------------------------------------------------------------
// int_ctrl
// Interrupt controller slave on the bridge: per-source edge/level latching,
// software mask and a fixed-priority claim register (lowest index wins).
//   clk, reset : system clock, synchronous active-high reset
//   irq_in     : raw requests, bit i = source i
//   Addr       : word address from the bridge; register chosen by Addr[3:2]
//   WE, Din    : write strobe (already range-decoded) and write data
//   Dout       : combinational read of the selected register
//   int_out    : pend & mask, drives CPU HWInt[NSRC-1:0]
//   irq_any    : OR of int_out
// ---------------------------------------------------------------------------
module int_ctrl
   import int_ctrl_pkg::*;
#(
   parameter int NSRC = 3,
   parameter int IDW  = 3
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [NSRC-1:0] irq_in,
   input  logic [29:0]     Addr,
   input  logic            WE,
   input  logic [31:0]     Din,
   output logic [31:0]     Dout,
   output logic [NSRC-1:0] int_out,
   output logic            irq_any
);

   logic [1:0]      reg_off;
   logic            wr_pend, wr_mask, wr_mode, wr_claim;
   logic [NSRC-1:0] pend, mode, clr;
   logic [NSRC-1:0] mask_reg;
   logic [IDW-1:0]  claim_id;
   logic            unused_bits;

   assign reg_off  = Addr[3:2];
   assign wr_pend  = WE && (reg_off == INTC_PEND);
   assign wr_mask  = WE && (reg_off == INTC_MASK);
   assign wr_mode  = WE && (reg_off == INTC_MODE);
   assign wr_claim = WE && (reg_off == INTC_CLAIM);

   // Only the low address and data bits carry meaning.
   assign unused_bits = ^{Addr[29:4], Addr[1:0], Din};

   generate
      for (genvar gi = 0; gi < NSRC; gi++) begin : g_src
         // EOI ids >= NSRC match no cell and are therefore ignored; the
         // cell itself disregards clears while in level mode.
         assign clr[gi] = (wr_pend && Din[gi]) ||
                          (wr_claim && (Din[IDW-1:0] == IDW'(gi)));

         int_src_cell u_cell (
            .clk      (clk),
            .reset    (reset),
            .irq_in   (irq_in[gi]),
            .mode_we  (wr_mode),
            .mode_din (Din[gi]),
            .clr      (clr[gi]),
            .pend     (pend[gi]),
            .mode     (mode[gi])
         );
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (reset) begin
         mask_reg <= '0;
      end else if (wr_mask) begin
         mask_reg <= Din[NSRC-1:0];
      end
   end

   assign int_out = pend & mask_reg;
   assign irq_any = |int_out;

   // Scan from the top down so the lowest active index is the final value.
   always_comb begin
      claim_id = '0;
      for (int i = NSRC - 1; i >= 0; i--) begin
         if (int_out[i]) begin
            claim_id = IDW'(i);
         end
      end
   end

   always_comb begin
      Dout = '0;
      case (reg_off)
         INTC_PEND:  Dout = 32'(pend);
         INTC_MASK:  Dout = 32'(mask_reg);
         INTC_MODE:  Dout = 32'(mode);
         INTC_CLAIM: Dout = {irq_any, {(31 - IDW){1'b0}}, claim_id};
         default:    Dout = '0;
      endcase
   end

endmodule

// File: tb/tb_int_ctrl.sv
// ---------------------------------------------------------------------------
// tb_int_ctrl
// Table of {reset, irq_in, bus write, read offset, expected Dout/int_out}
// rows; each row is applied over one clock edge, its expectation is queued
// when driven and popped when the outputs are sampled after the edge.
// ---------------------------------------------------------------------------
module tb_int_ctrl;
   import int_ctrl_pkg::*;

   localparam int NSRC = 3;
   localparam int IDW  = 3;

   logic            clk;
   logic            reset;
   logic [NSRC-1:0] irq_in;
   logic [29:0]     Addr;
   logic            WE;
   logic [31:0]     Din;
   logic [31:0]     Dout;
   logic [NSRC-1:0] int_out;
   logic            irq_any;

   int_ctrl #(.NSRC(NSRC), .IDW(IDW)) dut (
      .clk     (clk),
      .reset   (reset),
      .irq_in  (irq_in),
      .Addr    (Addr),
      .WE      (WE),
      .Din     (Din),
      .Dout    (Dout),
      .int_out (int_out),
      .irq_any (irq_any)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic        rst;
      logic [2:0]  irq;
      logic        we;
      logic [1:0]  woff;
      logic [31:0] din;
      logic [1:0]  roff;
      logic [31:0] exp_dout;
      logic [2:0]  exp_int;
   } vec_t;

   typedef struct {
      string       name;
      logic [31:0] dout;
      logic [2:0]  intv;
      logic        any;
   } exp_t;

   vec_t vecs[$];
   exp_t sb[$];
   int   errors = 0;
   int   checks = 0;

   task automatic add(input string n, input logic rst, input logic [2:0] irq,
                      input logic we, input logic [1:0] woff, input logic [31:0] din,
                      input logic [1:0] roff, input logic [31:0] ed, input logic [2:0] ei);
      vec_t v;
      v.name = n; v.rst = rst; v.irq = irq; v.we = we; v.woff = woff;
      v.din = din; v.roff = roff; v.exp_dout = ed; v.exp_int = ei;
      vecs.push_back(v);
   endtask

   task automatic cmp(input string what, input string n,
                      input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s %s: got %h expected %h", n, what, act, exp);
      end
   endtask

   task automatic check_out();
      exp_t e;
      if (sb.size() == 0) begin
         checks++;
         errors++;
         $display("FAIL scoreboard: got empty queue expected an entry");
      end else begin
         e = sb.pop_front();
         cmp("dout", e.name, Dout, e.dout);
         cmp("int_out", e.name, 32'(int_out), 32'(e.intv));
         cmp("irq_any", e.name, 32'(irq_any), 32'(e.any));
         $display("%-12s rd_off=%0d dout=%h int_out=%b irq_any=%b",
                  e.name, Addr[3:2], Dout, int_out, irq_any);
      end
   endtask

   task automatic apply(input vec_t v);
      exp_t e;
      @(negedge clk);
      reset  = v.rst;
      irq_in = v.irq;
      WE     = v.we;
      Addr   = {26'd0, v.woff, 2'd0};
      Din    = v.din;
      e.name = v.name;
      e.dout = v.exp_dout;
      e.intv = v.exp_int;
      e.any  = |v.exp_int;
      sb.push_back(e);
      @(posedge clk);
      #1;
      WE   = 1'b0;
      Addr = {26'd0, v.roff, 2'd0};
      #1;
      check_out();
   endtask

   initial begin
      reset  = 1'b1;
      irq_in = '0;
      Addr   = '0;
      WE     = 1'b0;
      Din    = '0;
      repeat (2) @(posedge clk);

      //   name          rst irq     we    woff        din    roff        exp_dout       exp_int
      add("rst_pend",   0, 3'b000, 1'b0, INTC_PEND,  32'd0, INTC_PEND,  32'h0,         3'b000);
      add("rst_mask",   0, 3'b000, 1'b0, INTC_PEND,  32'd0, INTC_MASK,  32'h0,         3'b000);
      add("rst_mode",   0, 3'b000, 1'b0, INTC_PEND,  32'd0, INTC_MODE,  32'h0,         3'b000);
      add("rst_claim",  0, 3'b000, 1'b0, INTC_PEND,  32'd0, INTC_CLAIM, 32'h0,         3'b000);
      // level mode, only source 1 unmasked
      add("lv_mode",    0, 3'b000, 1'b1, INTC_MODE,  32'd0, INTC_MODE,  32'h0,         3'b000);
      add("lv_mask",    0, 3'b000, 1'b1, INTC_MASK,  32'd2, INTC_MASK,  32'h2,         3'b000);
      add("lv_rise",    0, 3'b010, 1'b0, INTC_PEND,  32'd0, INTC_CLAIM, 32'h8000_0001, 3'b010);
      add("lv_w1c_ign", 0, 3'b010, 1'b1, INTC_PEND,  32'd2, INTC_PEND,  32'h2,         3'b010);
      add("lv_hold",    0, 3'b010, 1'b0, INTC_PEND,  32'd0, INTC_CLAIM, 32'h8000_0001, 3'b010);
      add("lv_fall",    0, 3'b000, 1'b0, INTC_PEND,  32'd0, INTC_CLAIM, 32'h0,         3'b000);
      // edge mode, all unmasked, two pulses then EOI and W1C
      add("eg_mode",    0, 3'b000, 1'b1, INTC_MODE,  32'd7, INTC_MODE,  32'h7,         3'b000);
      add("eg_mask",    0, 3'b000, 1'b1, INTC_MASK,  32'd7, INTC_MASK,  32'h7,         3'b000);
      add("eg_p2",      0, 3'b100, 1'b0, INTC_PEND,  32'd0, INTC_CLAIM, 32'h8000_0002, 3'b100);
      add("eg_p2_hold", 0, 3'b000, 1'b0, INTC_PEND,  32'd0, INTC_PEND,  32'h4,         3'b100);
      add("eg_p0",      0, 3'b001, 1'b0, INTC_PEND,  32'd0, INTC_CLAIM, 32'h8000_0000, 3'b101);
      add("eg_held",    0, 3'b000, 1'b0, INTC_PEND,  32'd0, INTC_PEND,  32'h5,         3'b101);
      add("eg_eoi0",    0, 3'b000, 1'b1, INTC_CLAIM, 32'd0, INTC_CLAIM, 32'h8000_0002, 3'b100);
      add("eg_w1c2",    0, 3'b000, 1'b1, INTC_PEND,  32'd4, INTC_CLAIM, 32'h0,         3'b000);
      // masked edge stays pending, unmask later
      add("mk_mask0",   0, 3'b000, 1'b1, INTC_MASK,  32'd0, INTC_MASK,  32'h0,         3'b000);
      add("mk_p1",      0, 3'b010, 1'b0, INTC_PEND,  32'd0, INTC_PEND,  32'h2,         3'b000);
      add("mk_claim",   0, 3'b000, 1'b0, INTC_PEND,  32'd0, INTC_CLAIM, 32'h0,         3'b000);
      add("mk_unmask",  0, 3'b000, 1'b1, INTC_MASK,  32'd2, INTC_CLAIM, 32'h8000_0001, 3'b010);
      add("mk_eoi_oor", 0, 3'b000, 1'b1, INTC_CLAIM, 32'd7, INTC_PEND,  32'h2,         3'b010);
      add("mk_eoi1",    0, 3'b000, 1'b1, INTC_CLAIM, 32'd1, INTC_PEND,  32'h0,         3'b000);
      // set beats W1C on the same edge
      add("sw_mask",    0, 3'b000, 1'b1, INTC_MASK,  32'd7, INTC_MASK,  32'h7,         3'b000);
      add("sw_p0",      0, 3'b001, 1'b0, INTC_PEND,  32'd0, INTC_PEND,  32'h1,         3'b001);
      add("sw_low",     0, 3'b000, 1'b0, INTC_PEND,  32'd0, INTC_PEND,  32'h1,         3'b001);
      add("sw_race",    0, 3'b001, 1'b1, INTC_PEND,  32'd1, INTC_PEND,  32'h1,         3'b001);
      add("sw_clear",   0, 3'b000, 1'b1, INTC_PEND,  32'd1, INTC_PEND,  32'h0,         3'b000);
      // mode switches with source 1 held high
      add("ms_to_lv",   0, 3'b000, 1'b1, INTC_MODE,  32'd5, INTC_MODE,  32'h5,         3'b000);
      add("ms_lv_hi",   0, 3'b010, 1'b0, INTC_PEND,  32'd0, INTC_PEND,  32'h2,         3'b010);
      add("ms_to_eg",   0, 3'b010, 1'b1, INTC_MODE,  32'd7, INTC_PEND,  32'h0,         3'b000);
      add("ms_eg_hold", 0, 3'b010, 1'b0, INTC_PEND,  32'd0, INTC_PEND,  32'h0,         3'b000);
      add("ms_eg_low",  0, 3'b000, 1'b0, INTC_PEND,  32'd0, INTC_PEND,  32'h0,         3'b000);
      add("ms_eg_rise", 0, 3'b010, 1'b0, INTC_PEND,  32'd0, INTC_CLAIM, 32'h8000_0001, 3'b010);
      add("ms_to_lv2",  0, 3'b000, 1'b1, INTC_MODE,  32'd5, INTC_PEND,  32'h2,         3'b010);
      add("ms_lv_fol",  0, 3'b000, 1'b0, INTC_PEND,  32'd0, INTC_PEND,  32'h0,         3'b000);

      foreach (vecs[i]) begin
         apply(vecs[i]);
      end

      // Reset in the middle of operation with an edge event pending.
      vecs.delete();
      add("mr_pend",    0, 3'b001, 1'b0, INTC_PEND,  32'd0, INTC_CLAIM, 32'h8000_0000, 3'b001);
      add("mr_reset",   1, 3'b001, 1'b0, INTC_PEND,  32'd0, INTC_PEND,  32'h0,         3'b000);
      add("mr_mask",    0, 3'b000, 1'b0, INTC_PEND,  32'd0, INTC_MASK,  32'h0,         3'b000);
      add("mr_mode",    0, 3'b000, 1'b0, INTC_PEND,  32'd0, INTC_MODE,  32'h0,         3'b000);
      add("mr_lv_msk",  0, 3'b100, 1'b0, INTC_PEND,  32'd0, INTC_PEND,  32'h4,         3'b000);
      add("mr_unmask",  0, 3'b100, 1'b1, INTC_MASK,  32'd4, INTC_CLAIM, 32'h8000_0002, 3'b100);
      foreach (vecs[i]) begin
         apply(vecs[i]);
      end

      if (sb.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL scoreboard_drain: got %0d entries expected 0", sb.size());
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/int_ctrl.md
Name: int_ctrl

Overview:
- Memory-mapped interrupt controller between the peripheral IRQ lines (TC0 IRQ, TC1 IRQ, external interrupt) and the CPU HWInt vector.
- Latches each source as edge- or level-triggered, applies a software mask and exposes a priority-encoded claim register.
- Sits behind the bridge as a third device with the same Addr/WE/Din/Dout slave interface as the timers.
- Drives the low bits of HWInt in place of the raw IRQ wires.

Parameters:
- NSRC, 3, number of interrupt sources (1..6); bit i of irq_in is source i.
- IDW, 3, width of the source id field in CLAIM; must satisfy 2^IDW > NSRC.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- irq_in  input  NSRC  raw interrupt requests; synchronous to clk; bit0 TC0, bit1 TC1, bit2 external
- Addr  input  30  word address from the bridge (byte address [31:2]); only Addr[3:2] decoded
- WE  input  1  write strobe from the bridge, already range-decoded
- Din  input  32  write data
- Dout  output  32  read data for the word selected by Addr[3:2]
- int_out  output  NSRC  pending & mask, to CPU HWInt[NSRC-1:0]
- irq_any  output  1  OR of int_out

Behaviour:
- Registers, all reset to 0; a synchronous reset mid-operation clears all pending state:
  - pend[NSRC-1:0]
  - mask[NSRC-1:0]
  - mode[NSRC-1:0] (1 = edge, 0 = level)
  - prev[NSRC-1:0]
- Register map, word offsets via Addr[3:2]:
  - 0 PEND: read = pend; write = W1C on edge-mode bits, ignored for level-mode bits.
  - 1 MASK: read/write, Din[NSRC-1:0].
  - 2 MODE: read/write, Din[NSRC-1:0].
  - 3 CLAIM: read = {valid, 31-IDW zero bits, id}. valid = irq_any; id = lowest index i with int_out[i]=1, else 0. Write = EOI: clears pend[Din[IDW-1:0]] if that source is edge-mode and the id < NSRC; otherwise no effect.
- Unused upper bits read 0; writes to them are ignored.
- Dout is a combinational read of registers only; no read side effects.
- Level mode: pend[i] <= irq_in[i] every edge, so it lags by 1 cycle; W1C and EOI have no effect.
- Edge mode:
  - prev[i] <= irq_in[i] every edge.
  - pend[i] is set on any edge where irq_in[i]=1 && prev[i]=0.
  - pend[i] is cleared only by W1C/EOI.
- Simultaneous set and clear on the same edge: set wins, so no event is lost.
- Mode change via a write to MODE:
  - Bits switching level→edge: pend cleared; prev loaded with the current irq_in, so no spurious edge.
  - Bits switching edge→level: pend follows irq_in from the next edge.
- Outputs:
  - int_out = pend & mask, combinational from registers only; there is no combinational path from irq_in or the bus to int_out.
  - Latency from an irq_in rise to int_out: 1 clock edge.
- Masking does not discard pending edges: unmasking later asserts int_out immediately.
- Priority is fixed: lower index is higher priority. Only CLAIM applies priority; int_out presents all active sources.
- WE with Addr[3:2] outside the map cannot occur (the 2-bit field is fully decoded). Writes take effect on the edge where WE=1.
- Reset values: Dout = 0 for PEND, MASK, MODE and CLAIM reads; int_out = 0; irq_any = 0.

Decomposition:
- Shared package (or header of defines):
  - register offsets INTC_PEND = 2'd0, INTC_MASK = 2'd1, INTC_MODE = 2'd2, INTC_CLAIM = 2'd3
  - base address of the device window for the bridge
  - source index constants SRC_TC0 = 0, SRC_TC1 = 1, SRC_EXT = 2
- One sub-module is natural: int_src_cell.
  - Per-source prev/pend flop pair with edge/level logic, set-wins-clear and mode-switch handling.
  - Instantiated NSRC times in a generate loop.
  - The top adds register decode, mask, priority encoder and read mux.

Test Plan:
- Reset, then read all four offsets -> Dout = 0 every time; int_out = 0; irq_any = 0.
- MODE = 3'b000, MASK = 3'b010; hold irq_in[1] high 3 cycles then low -> int_out = 3'b010 from 1 edge after the rise; int_out = 0 one edge after the fall; CLAIM reads 0x80000001 while asserted.
- MODE = 3'b111, MASK = 3'b111; pulse irq_in[2] for 1 cycle, then irq_in[0] -> pend = 3'b101 held after the pulses; CLAIM = 0x80000000; EOI write 0 -> CLAIM = 0x80000002; W1C PEND 3'b100 -> pend = 0; irq_any = 0.
- Edge mode, MASK = 0; pulse irq_in[1] -> pend[1] = 1, int_out = 0; then write MASK = 3'b010 -> int_out = 3'b010 on the next cycle.
- Edge mode; W1C PEND bit 0 on the same edge as a new irq_in[0] rise -> pend[0] remains 1.
- irq_in[1] held high, MODE bit 1 written 0→1 -> no pend[1] set (prev preloaded); pend[1] sets only after irq_in[1] falls and rises again.
